al_bw_streamer: RTL and testbench
=================================

Name: al_bw_streamer

Overview:
- Transmit end of the activation-loader → column-buffer interface. Drives al_bw_data/al_bw_valid into the PE array's column-buffer ports and honours the per-lane al_bw_ready0/al_bw_ready1 (double-bank) back-pressure.
- Pulls wide beats from a loader source stream and broadcasts each beat, as one registered beat, to a masked subset of ARRAY_WIDTH lanes.
- Runs one command at a time: beat count, bank select and lane mask. Reports progress on a state port.

Parameters:
- ARRAY_WIDTH, 16, number of column lanes (taken from RISA_PKG by default).
- QSIZE, 8, bits per lane datum.
- LEN_W, 16, width of the beat-count field.
- STATE_WIDTH, 4, width of the state report port.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rstn  in  1  reset; synchronous, active-high (asserted = 1).
- cmd_valid  in  1  command offer.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  LEN_W  beats to send.
- cmd_bank  in  1  0 = use al_bw_ready0, 1 = use al_bw_ready1.
- cmd_mask  in  ARRAY_WIDTH  lanes that participate.
- abort  in  1  flush the current command.
- src_data  in  QSIZE x [0:ARRAY_WIDTH-1]  source beat, one datum per lane.
- src_valid  in  1  source beat valid.
- src_ready  out  1  source beat accepted when src_valid & src_ready.
- al_bw_data  out  QSIZE x [0:ARRAY_WIDTH-1]  lane data.
- al_bw_valid  out  1 x [0:ARRAY_WIDTH-1]  lane valid.
- al_bw_ready0  in  1 x [0:ARRAY_WIDTH-1]  bank-0 readiness per lane.
- al_bw_ready1  in  1 x [0:ARRAY_WIDTH-1]  bank-1 readiness per lane.
- done  out  1  one-cycle pulse at command completion.
- o_stateport_al  out  STATE_WIDTH  {state[1:0], out_full, bank}.

Behaviour:
- **Reset** (rstn=1 at an edge):
  - state=IDLE; counters=0; out_full=0.
  - all al_bw_valid=0, al_bw_data=0, done=0, src_ready=0, cmd_ready=1.
  - Reset mid-command discards the held beat, with no further valids.
- **States:** IDLE, STREAM, DONE.
  - IDLE → STREAM on cmd_valid & cmd_ready with cmd_len>0. Latch len, bank, mask; clear issued and sent.
  - IDLE → DONE when cmd_len==0 (no beats sent).
  - STREAM → DONE on the fire that makes sent==len.
  - DONE → IDLE after one cycle, with done=1 in DONE.
  - abort in STREAM → IDLE next cycle. Clears out_full and all valids; no done pulse. abort in IDLE or DONE is ignored.
- **Output register:** out_full plus a held beat.
  - al_bw_valid[i] = out_full & mask[i].
  - Unmasked lanes: valid=0, data=0.
- **Handshake:**
  - sel_ready[i] = bank ? al_bw_ready1[i] : al_bw_ready0[i].
  - fire = out_full & AND over i of (~mask[i] | sel_ready[i]).
  - Data and valid are held stable until fire; no lane sees a partial beat.
  - mask = 0 with len>0: fire whenever out_full, so beats drain with no lane activity.
- **Source side:**
  - src_ready = (state==STREAM) & (issued<len) & (~out_full | fire). src_ready is combinational from ready inputs.
  - On a source accept: out register loads next cycle; issued++.
  - fire without accept: out_full clears. fire with accept: back-to-back beats, out_full stays 1.
- **Throughput and latency:**
  - Throughput: 1 beat/cycle when source and readies are continuously high.
  - Latency: source accept at edge t → al_bw_valid high from t+1.
- **Counters:** LEN_W-bit, no wrap; issued and sent never exceed len. Max len = 2^LEN_W-1.
- **Command port:** cmd_valid outside IDLE is not accepted (cmd_ready=0). The next command may be accepted in the cycle after DONE.

Decomposition:
- RISA_PKG gains:
  - AlStreamState enum (IDLE=0, STREAM=1, DONE=2).
  - AL_LEN_W constant.
  - AlStreamCmd struct {len, bank, mask}.
- One natural sub-module: al_bw_out_stage, the held-beat register with its mask/fire logic.
- Counters and FSM stay in the top.

Test Plan:
- **Basic stream:** cmd len=4, bank=0, mask=all 1. Source 0x10..0x13 every cycle; ready0 all 1. Expect 4 consecutive valid cycles with lane data 0x10..0x13, then done one cycle after the last fire, then cmd_ready=1.
- **Bank select:** bank=1, ready0=all 1, ready1=0 for 3 cycles then all 1. Expect no fire while ready1=0, and beat 0 held stable for all 3 stall cycles.
- **Masked lanes:** mask=0x0005, ready1/ready0 low on all unmasked lanes. Expect only lanes 0 and 2 valid, transfer unblocked, other lanes data=0.
- **Partial ready:** lane 3 selected ready low for 2 cycles. Expect the whole beat stalled, src_ready=0 during the stall, then resume with no duplicated or lost beat (sent count = len exactly).
- **Abort / reset:** abort at sent=2 of len=8 → valids drop next cycle, no done, cmd_ready=1. rstn=1 mid-stream → all outputs at reset values.
- **Zero length:** cmd len=0 → done pulse one cycle after accept, no src_ready, no valid.

Source files
------------

// File: rtl/al_bw_streamer_pkg.sv
// Shared types for the activation-loader to column-buffer streamer.
package al_bw_streamer_pkg;

    localparam int AL_ARRAY_WIDTH = 16;
    localparam int AL_QSIZE       = 8;
    localparam int AL_LEN_W       = 16;
    localparam int AL_STATE_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } AlStreamState;

    typedef struct packed {
        logic [AL_LEN_W-1:0]       len;
        logic                      bank;
        logic [AL_ARRAY_WIDTH-1:0] mask;
    } AlStreamCmd;

endpackage

// File: rtl/al_bw_streamer_if.sv
// Source beat stream plus the per-lane column-buffer bus (data/valid, two ready banks).
interface al_bw_streamer_if
    import al_bw_streamer_pkg::*;
#(
    parameter int ARRAY_WIDTH = AL_ARRAY_WIDTH,
    parameter int QSIZE       = AL_QSIZE
);
    logic [ARRAY_WIDTH-1:0][QSIZE-1:0] src_data;
    logic                              src_valid;
    logic                              src_ready;
    logic [ARRAY_WIDTH-1:0][QSIZE-1:0] al_bw_data;
    logic [ARRAY_WIDTH-1:0]            al_bw_valid;
    logic [ARRAY_WIDTH-1:0]            al_bw_ready0;
    logic [ARRAY_WIDTH-1:0]            al_bw_ready1;

    modport master (
        input  src_data, src_valid, al_bw_ready0, al_bw_ready1,
        output src_ready, al_bw_data, al_bw_valid
    );

    modport slave (
        output src_data, src_valid, al_bw_ready0, al_bw_ready1,
        input  src_ready, al_bw_data, al_bw_valid
    );
endinterface

// File: rtl/al_bw_streamer_out.sv
// Held-beat output register: one beat broadcast to the masked lanes, released only
// when every masked lane's selected bank is ready.
module al_bw_out_stage
    import al_bw_streamer_pkg::*;
#(
    parameter int ARRAY_WIDTH = AL_ARRAY_WIDTH,
    parameter int QSIZE       = AL_QSIZE
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              clear,
    input  logic                              load,
    input  logic                              bank,
    input  logic [ARRAY_WIDTH-1:0]            mask,
    input  logic [ARRAY_WIDTH-1:0]            ready0,
    input  logic [ARRAY_WIDTH-1:0]            ready1,
    input  logic [ARRAY_WIDTH-1:0][QSIZE-1:0] load_data,
    output logic                              out_full,
    output logic                              fire,
    output logic [ARRAY_WIDTH-1:0]            lane_valid,
    output logic [ARRAY_WIDTH-1:0][QSIZE-1:0] lane_data
);
    logic [ARRAY_WIDTH-1:0] lane_ok;

    for (genvar i = 0; i < ARRAY_WIDTH; i++) begin : g_lane
        logic             v_q;
        logic [QSIZE-1:0] d_q;

        assign lane_ok[i] = ~mask[i] | (bank ? ready1[i] : ready0[i]);

        // Unmasked lanes latch zero so they never show stale data.
        always_ff @(posedge clk) begin
            if (rstn || clear) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (load) begin
                v_q <= mask[i];
                d_q <= mask[i] ? load_data[i] : '0;
            end else if (fire) begin
                v_q <= 1'b0;
            end
        end

        assign lane_valid[i] = v_q;
        assign lane_data[i]  = d_q;
    end

    assign fire = out_full & (&lane_ok);

    always_ff @(posedge clk) begin
        if (rstn || clear)
            out_full <= 1'b0;
        else if (load)
            out_full <= 1'b1;
        else if (fire)
            out_full <= 1'b0;
    end

endmodule

// File: rtl/al_bw_streamer.sv
// Activation-loader transmit end: runs one command at a time, pulling source beats
// and broadcasting each to the masked column lanes on the selected ready bank.
module al_bw_streamer
    import al_bw_streamer_pkg::*;
#(
    parameter int ARRAY_WIDTH = AL_ARRAY_WIDTH,
    parameter int QSIZE       = AL_QSIZE,
    parameter int LEN_W       = AL_LEN_W,
    parameter int STATE_WIDTH = AL_STATE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic                   cmd_bank,
    input  logic [ARRAY_WIDTH-1:0] cmd_mask,
    input  logic                   abort,
    al_bw_streamer_if.master       bus,
    output logic                   done,
    output logic [STATE_WIDTH-1:0] o_stateport_al
);
    AlStreamState     state;
    AlStreamCmd       cmd_q;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] sent;
    logic             out_full;
    logic             fire;
    logic             src_ready;
    logic             accept;
    logic             streaming;
    logic             last_fire;

    assign streaming = (state == STREAM);
    // Take a new beat only if the register is empty or emptying this cycle.
    assign src_ready = streaming & (issued < cmd_q.len) & (~out_full | fire);
    assign accept    = bus.src_valid & src_ready;
    assign last_fire = fire & (sent == cmd_q.len - LEN_W'(1));

    assign bus.src_ready  = src_ready;
    assign cmd_ready      = (state == IDLE);
    assign done           = (state == DONE);
    assign o_stateport_al = STATE_WIDTH'({state, out_full, cmd_q.bank});

    al_bw_out_stage #(
        .ARRAY_WIDTH (ARRAY_WIDTH),
        .QSIZE       (QSIZE)
    ) u_out (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (streaming & abort),
        .load       (accept),
        .bank       (cmd_q.bank),
        .mask       (cmd_q.mask),
        .ready0     (bus.al_bw_ready0),
        .ready1     (bus.al_bw_ready1),
        .load_data  (bus.src_data),
        .out_full   (out_full),
        .fire       (fire),
        .lane_valid (bus.al_bw_valid),
        .lane_data  (bus.al_bw_data)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state  <= IDLE;
            cmd_q  <= '0;
            issued <= '0;
            sent   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q.len  <= cmd_len;
                        cmd_q.bank <= cmd_bank;
                        cmd_q.mask <= cmd_mask;
                        issued     <= '0;
                        sent       <= '0;
                        state      <= (cmd_len == '0) ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        if (accept)
                            issued <= issued + LEN_W'(1);
                        if (fire)
                            sent <= sent + LEN_W'(1);
                        if (last_fire)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_al_bw_streamer.sv
// Randomized scoreboard bench for al_bw_streamer: driver models the command/beat
// flow at transaction level, a separate monitor checks every presented beat.
module tb_al_bw_streamer;
    import al_bw_streamer_pkg::*;

    localparam int AW = 16;
    localparam int Q  = 8;
    localparam int LW = 16;

    typedef logic [AW-1:0][Q-1:0] beat_t;
    typedef struct {
        beat_t         data;
        logic [AW-1:0] mask;
        logic          bank;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          cmd_bank;
    logic [AW-1:0] cmd_mask;
    logic          abort;
    logic          done;
    logic [3:0]    o_stateport_al;

    al_bw_streamer_if #(.ARRAY_WIDTH(AW), .QSIZE(Q)) bus ();

    al_bw_streamer #(
        .ARRAY_WIDTH (AW),
        .QSIZE       (Q),
        .LEN_W       (LW),
        .STATE_WIDTH (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_len        (cmd_len),
        .cmd_bank       (cmd_bank),
        .cmd_mask       (cmd_mask),
        .abort          (abort),
        .bus            (bus),
        .done           (done),
        .o_stateport_al (o_stateport_al)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   total     = 0;
    int   bad       = 0;
    int   nfired    = 0;
    int   exp_fired = 0;

    task automatic chk(input string nm, input logic [AW*Q-1:0] a, input logic [AW*Q-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic beat_t mk_beat(input int base, input int k);
        beat_t b;
        for (int i = 0; i < AW; i++)
            b[i] = (base >= 0) ? Q'(base + k) : Q'($urandom);
        return b;
    endfunction

    function automatic beat_t masked(input beat_t b, input logic [AW-1:0] m);
        beat_t r;
        for (int i = 0; i < AW; i++)
            r[i] = m[i] ? b[i] : '0;
        return r;
    endfunction

    // Monitor: whenever a beat is presented, it must equal the scoreboard head;
    // the head retires when all its lanes see their selected ready.
    initial begin
        exp_t          e;
        logic [AW-1:0] sel;
        forever begin
            @(negedge clk);
            #2;
            if (rstn) continue;
            if (o_stateport_al[1]) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: beat presented, none expected at %0t", $time);
                end else begin
                    e = sb[0];
                    chk("lane_data", bus.al_bw_data, e.data);
                    chk("lane_valid", bus.al_bw_valid, e.mask);
                    sel = e.bank ? bus.al_bw_ready1 : bus.al_bw_ready0;
                    if (&(~e.mask | sel)) begin
                        @(posedge clk);
                        if (!rstn) begin
                            void'(sb.pop_front());
                            nfired++;
                        end
                    end
                end
            end else begin
                chk("idle_valid", bus.al_bw_valid, '0);
            end
        end
    end

    task automatic idle_gap(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cmd_valid     = 1'b0;
            abort         = 1'($urandom);
            bus.src_valid = 1'($urandom);
            #1;
            chk("gap_cmd_ready", cmd_ready, 1);
            chk("gap_done", done, 0);
            chk("gap_src_ready", bus.src_ready, 0);
        end
        abort = 1'b0;
    endtask

    // rmode: 0 readies all high, 1 random readies/source, 2 readies = mask only.
    task automatic run_cmd(input int len, input logic bank, input logic [AW-1:0] mask,
                           input int rmode, input logic [AW-1:0] stall_lanes,
                           input int stall_cyc, input int abort_at, input int rst_at,
                           input int base);
        int            issued = 0;
        int            sent   = 0;
        int            cyc    = 0;
        bit            hold   = 0;
        bit            fire_m;
        bit            rdy_m;
        beat_t         beat;
        logic [AW-1:0] r0, r1, sel;
        exp_t          e;

        beat = mk_beat(base, 0);
        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_len       = LW'(len);
        cmd_bank      = bank;
        cmd_mask      = mask;
        abort         = 1'b0;
        bus.src_valid = 1'b0;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        chk("done_idle", done, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (len == 0) begin
            #1;
            chk("zl_done", done, 1);
            chk("zl_src_ready", bus.src_ready, 0);
            chk("zl_valid", bus.al_bw_valid, 0);
            chk("zl_cmd_ready", cmd_ready, 0);
            @(negedge clk);
            #1;
            chk("zl_done_drop", done, 0);
            chk("zl_cmd_ready_back", cmd_ready, 1);
            return;
        end

        while (sent < len) begin
            case (rmode)
                0: begin r0 = '1; r1 = '1; end
                1: begin
                    r0 = ($urandom % 2) ? '1 : AW'($urandom);
                    r1 = ($urandom % 2) ? '1 : AW'($urandom);
                end
                default: begin r0 = mask; r1 = mask; end
            endcase
            if (cyc < stall_cyc) begin
                if (bank) r1 = r1 & ~stall_lanes;
                else      r0 = r0 & ~stall_lanes;
            end
            bus.al_bw_ready0 = r0;
            bus.al_bw_ready1 = r1;
            bus.src_valid    = (rmode == 1) ? ($urandom % 4 != 0) : 1'b1;
            bus.src_data     = beat;
            cmd_valid        = 1'($urandom);
            cmd_len          = LW'($urandom);
            cmd_bank         = 1'($urandom);
            cmd_mask         = AW'($urandom);
            abort            = (sent == abort_at);
            rstn             = (sent == rst_at);
            if (abort || rstn) bus.src_valid = 1'b0;
            #1;
            sel    = bank ? r1 : r0;
            fire_m = hold && (&(~mask | sel));
            rdy_m  = (issued < len) && (!hold || fire_m);
            if (!rstn) begin
                chk("src_ready", bus.src_ready, rdy_m);
                chk("stateport", o_stateport_al, {2'b01, hold, bank});
                chk("done_stream", done, 0);
                chk("cmd_ready_stream", cmd_ready, 0);
            end
            if (abort || rstn) begin
                if (abort && fire_m) exp_fired++;
                @(negedge clk);
                sb.delete();
                abort         = 1'b0;
                cmd_valid     = 1'b0;
                bus.src_valid = 1'b0;
                #1;
                chk("flush_valid", bus.al_bw_valid, 0);
                chk("flush_done", done, 0);
                chk("flush_cmd_ready", cmd_ready, 1);
                chk("flush_src_ready", bus.src_ready, 0);
                if (rstn) begin
                    chk("rst_data", bus.al_bw_data, 0);
                    chk("rst_state", o_stateport_al, 0);
                end else begin
                    chk("abort_state", o_stateport_al, {3'b000, bank});
                end
                rstn = 1'b0;
                @(negedge clk);
                #1;
                chk("flush_done_after", done, 0);
                chk("flush_cmd_ready_after", cmd_ready, 1);
                return;
            end
            if (bus.src_valid && rdy_m) begin
                e.data = masked(beat, mask);
                e.mask = mask;
                e.bank = bank;
                sb.push_back(e);
                issued++;
                beat = mk_beat(base, issued);
            end
            if (fire_m) begin
                sent++;
                exp_fired++;
            end
            hold = (issued > sent);
            cyc++;
            if (cyc > 500) begin
                total++;
                bad++;
                $display("FAIL stream_timeout: sent=%0d want=%0d", sent, len);
                rstn = 1'b1;
                @(negedge clk);
                sb.delete();
                rstn = 1'b0;
                return;
            end
            @(negedge clk);
        end

        cmd_valid     = 1'b0;
        bus.src_valid = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("done_state", o_stateport_al, {2'b10, 1'b0, bank});
        chk("done_cmd_ready", cmd_ready, 0);
        chk("done_valid", bus.al_bw_valid, 0);
        chk("done_src_ready", bus.src_ready, 0);
        @(negedge clk);
        #1;
        chk("done_drop", done, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        int            len;
        int            ab;
        logic [AW-1:0] m;
        cmd_valid        = 1'b0;
        cmd_len          = '0;
        cmd_bank         = 1'b0;
        cmd_mask         = '0;
        abort            = 1'b0;
        rstn             = 1'b1;
        bus.src_valid    = 1'b0;
        bus.src_data     = '0;
        bus.al_bw_ready0 = '0;
        bus.al_bw_ready1 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        chk("rst_valid", bus.al_bw_valid, 0);
        chk("rst_data0", bus.al_bw_data, 0);
        chk("rst_stateport", o_stateport_al, 0);
        @(negedge clk);
        rstn = 1'b0;
        idle_gap(2);

        run_cmd(4, 1'b0, '1, 0, '0, 0, -1, -1, 16'h10);
        idle_gap(1);
        run_cmd(3, 1'b1, '1, 0, '1, 4, -1, -1, -1);
        run_cmd(4, 1'b1, 16'h0005, 2, '0, 0, -1, -1, -1);
        run_cmd(4, 1'b0, 16'h0005, 2, '0, 0, -1, -1, -1);
        run_cmd(5, 1'b0, '1, 0, 16'h0008, 3, -1, -1, -1);
        run_cmd(8, 1'b0, '1, 0, '0, 0, 2, -1, -1);
        run_cmd(8, 1'b1, '1, 0, '0, 0, -1, 3, -1);
        run_cmd(0, 1'b0, '1, 0, '0, 0, -1, -1, -1);
        run_cmd(3, 1'b0, '0, 1, '0, 0, -1, -1, -1);

        for (int n = 0; n < 40; n++) begin
            len = $urandom % 11;
            case ($urandom % 4)
                0:       m = '1;
                1:       m = '0;
                default: m = AW'($urandom);
            endcase
            ab = (len > 0 && ($urandom % 8 == 0)) ? int'($urandom % len) : -1;
            run_cmd(len, 1'($urandom), m, 1, '0, 0, ab, -1, -1);
            idle_gap($urandom % 3);
        end

        repeat (3) @(negedge clk);
        #3;
        chk("sb_drain", sb.size(), 0);
        chk("beats_fired", nfired, exp_fired);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
